// File: rtl/ifid_buffer_pkg.sv
// Shared constants for the fetch-to-decode instruction buffer.
package ifid_buffer_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam int          DEPTH_DEF = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/ifid_regfile.sv
// Entry storage for the IF/ID buffer: synchronous write, asynchronous read.
// Contents are deliberately not reset; the buffer masks invalid entries.
module ifid_regfile #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write one entry per cycle when enabled.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifid_buffer.sv
// In-order FIFO of {pc, instr} pairs between fetch and decode.
// Head entry is shown ahead from storage; empty outputs read as a NOP at pc 0.
module ifid_buffer
  import ifid_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW   = $clog2(DEPTH);
  localparam int             CW   = AW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  logic [AW-1:0]      r_rptr;
  logic [AW-1:0]      r_wptr;
  logic [CW-1:0]      r_count;
  logic               w_push;
  logic               w_pop;
  logic               w_we;
  logic [2*XLEN-1:0]  w_rdata;

  // Handshake flags come only from registered occupancy; no full-and-pop pass-through.
  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign w_we      = w_push && !rst;
  assign count     = r_count;

  ifid_regfile #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_regfile (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata ({in_pc, in_instr}),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Mask stale storage so an empty buffer presents a NOP at pc 0.
  always_comb begin
    out_pc    = '0;
    out_instr = XLEN'(NOP_INSTR);
    if (out_valid) begin
      out_pc    = w_rdata[2*XLEN-1:XLEN];
      out_instr = w_rdata[XLEN-1:0];
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifid_buffer.sv
module tb_ifid_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  logic [63:0] sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  ifid_buffer #(.DEPTH(4), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the scoreboard predicts push/pop from its own occupancy.
  task automatic drive_cycle(input logic v, input logic [31:0] pc, input logic rdy,
                             input logic fl, input logic rs,
                             output logic exp_pop, output logic [63:0] exp_data,
                             output logic [63:0] act_data, output logic act_valid);
    logic exp_push;
    rst = rs; flush = fl; in_valid = v; in_pc = pc; in_instr = pc + 32'h100; out_ready = rdy;
    #1;
    act_valid = out_valid;
    act_data  = {out_pc, out_instr};
    exp_push  = v && (sb.size() != 4) && !fl && !rs;
    exp_pop   = rdy && (sb.size() != 0) && !fl && !rs;
    exp_data  = (sb.size() != 0) ? sb[0] : 64'h0;
    @(posedge clk);
    if (rs || fl) sb.delete();
    else begin
      if (exp_pop)  void'(sb.pop_front());
      if (exp_push) sb.push_back({pc, pc + 32'h100});
    end
    #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic ep, av; logic [63:0] ed, ad;
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, ep, ed, ad, av);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, ep, ed, ad, av);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if ({out_pc, out_instr} !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", {out_pc, out_instr}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_fill();
    logic ep, av; logic [63:0] ed, ad;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, ep, ed, ad, av);
      n_checks++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL fill_out_pc: got %h expected 0", out_pc); end
    n_checks++; if (out_instr !== 32'h100) begin n_fail++; $display("FAIL fill_out_instr: got %h expected 100", out_instr); end
  endtask

  task automatic test_full_pop();
    logic ep, av; logic [63:0] ed, ad;
    drive_cycle(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, ep, ed, ad, av);
    n_checks++; if (ad !== 64'h0000_0000_0000_0100) begin n_fail++; $display("FAIL fullpop_data: got %h expected 0000000000000100", ad); end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL fullpop_count: got %0d expected 3", count); end
    n_checks++; if (out_pc !== 32'h1) begin n_fail++; $display("FAIL fullpop_out_pc: got %h expected 1", out_pc); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_stream();
    logic ep, av; logic [63:0] ed, ad;
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, ep, ed, ad, av);
    n_checks++; if (ad !== {32'h1, 32'h101}) begin n_fail++; $display("FAIL stream_drain: got %h expected %h", ad, {32'h1, 32'h101}); end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 32'(4 + i), 1'b1, 1'b0, 1'b0, ep, ed, ad, av);
      n_checks++; if (ad !== {32'(2 + i), 32'(2 + i + 32'h100)}) begin n_fail++; $display("FAIL stream_pop[%0d]: got %h expected pc %0d", i, ad, 2 + i); end
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 2", i, count); end
    end
    n_checks++; if (out_pc !== 32'd12) begin n_fail++; $display("FAIL stream_head: got %0d expected 12", out_pc); end
  endtask

  task automatic test_flush();
    logic ep, av; logic [63:0] ed, ad;
    drive_cycle(1'b1, 32'd14, 1'b0, 1'b0, 1'b0, ep, ed, ad, av);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    drive_cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, ep, ed, ad, av);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    n_checks++; if ({out_pc, out_instr} !== 64'h0) begin n_fail++; $display("FAIL flush_out_data: got %h expected 0", {out_pc, out_instr}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, ep, ed, ad, av);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_discard: got %0d expected 0", count); end
  endtask

  task automatic test_empty_pop();
    logic ep, av; logic [63:0] ed, ad;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, ep, ed, ad, av);
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL empty_count[%0d]: got %0d expected 0", i, count); end
      n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL empty_out_pc[%0d]: got %h expected 0", i, out_pc); end
    end
    drive_cycle(1'b1, 32'h77, 1'b1, 1'b0, 1'b0, ep, ed, ad, av);
    n_checks++; if (av !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got out_valid %b expected 0", av); end
    n_checks++; if ({out_pc, out_instr, count} !== {32'h77, 32'h177, 3'd1}) begin n_fail++; $display("FAIL after_empty_push: got %h %h %0d expected 77 177 1", out_pc, out_instr, count); end
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, ep, ed, ad, av);
    n_checks++; if (ad !== {32'h77, 32'h177}) begin n_fail++; $display("FAIL after_empty_pop: got %h expected 0000007700000177", ad); end
  endtask

  task automatic test_reset_mid();
    logic ep, av; logic [63:0] ed, ad;
    drive_cycle(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, ep, ed, ad, av);
    drive_cycle(1'b1, 32'h21, 1'b0, 1'b0, 1'b0, ep, ed, ad, av);
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre_count: got %0d expected 2", count); end
    drive_cycle(1'b1, 32'h22, 1'b1, 1'b1, 1'b1, ep, ed, ad, av);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    drive_cycle(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, ep, ed, ad, av);
    n_checks++; if ({out_pc, out_instr} !== {32'h30, 32'h130}) begin n_fail++; $display("FAIL rstmid_repush: got %h expected 0000003000000130", {out_pc, out_instr}); end
  endtask

  task automatic test_random();
    logic ep, av; logic [63:0] ed, ad;
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0), ep, ed, ad, av);
      if (ep) begin
        n_checks++; if (ad !== ed) begin n_fail++; $display("FAIL rand_pop[%0d]: got %h expected %h", i, ad, ed); end
      end
      n_checks++; if (count !== 3'(sb.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, count, sb.size()); end
      n_checks++; if ({out_pc, out_instr} !== ((sb.size() != 0) ? sb[0] : 64'h0)) begin n_fail++; $display("FAIL rand_head[%0d]: got %h expected %h", i, {out_pc, out_instr}, (sb.size() != 0) ? sb[0] : 64'h0); end
      n_checks++; if (in_ready !== (sb.size() != 4)) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b", i, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_stream();
    test_flush();
    test_empty_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_buffer.md
IFID_BUFFER -- requirements
Module: ifid_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two, at least 2.
REQ-002 SHALL have parameter XLEN, default 32, giving the PC and instruction width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  fetch stage presents a valid instruction this cycle.
REQ-007 in_ready  out  1  buffer can accept an entry this cycle.
REQ-008 in_pc  in  XLEN  PC of the presented instruction.
REQ-009 in_instr  in  XLEN  fetched instruction word.
REQ-010 flush  in  1  taken branch; discard all buffered and incoming entries.
REQ-011 out_valid  out  1  head entry is valid for decode.
REQ-012 out_ready  in  1  decode consumes the head entry this cycle.
REQ-013 out_pc  out  XLEN  PC of the head entry.
REQ-014 out_instr  out  XLEN  instruction of the head entry.
REQ-015 count  out  log2(DEPTH)+1  number of occupied entries.

Function
REQ-016 SHALL act as an in-order FIFO of {pc, instr} pairs between fetch and decode.
REQ-017 Push occurs when in_valid && in_ready && !flush.
REQ-018 Pop occurs when out_valid && out_ready && !flush.
REQ-019 in_ready SHALL equal (count != DEPTH), combinational from registered state; there is no full-and-pop pass-through.
REQ-020 out_valid SHALL equal (count != 0); head data are presented show-ahead from storage.
REQ-021 Latency: an entry pushed at edge N SHALL be visible at the outputs after edge N; there is no same-cycle bypass when empty.
REQ-022 When out_valid=0, out_pc and out_instr SHALL be 0; instruction 0 is the NOP encoding.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 A pop when empty or a push when full SHALL have no effect; no state changes.
REQ-026 Flush has priority: count, read pointer and write pointer SHALL all be 0 after the edge; a same-cycle push or pop is discarded.
REQ-027 out_valid SHALL be 0 in the cycle after a flush; in_ready SHALL be 1.
REQ-028 Entries SHALL never be reordered, duplicated or dropped except by flush or rst.

Reset
REQ-029 While rst=1 at an edge, count, read pointer and write pointer SHALL become 0.
REQ-030 After reset: out_valid=0, out_pc=0, out_instr=0, in_ready=1.
REQ-031 Reset mid-operation SHALL discard all entries, identically to flush.
REQ-032 rst SHALL take priority over flush, push and pop.
REQ-033 Storage array contents are not reset; they are never observable while invalid.

Structure
REQ-034 A shared package SHALL hold XLEN, the NOP encoding (32'h0) and the default DEPTH.
REQ-035 Storage SHALL be one sub-module, ifid_regfile: DEPTH x 2*XLEN, one synchronous write port, one asynchronous read port.
REQ-036 Pointer and count logic SHALL stay in ifid_buffer.

Verification
REQ-037 Reset, then push pc=0..3 (instr=0x100+pc) with out_ready=0 -> count=4, in_ready=0, out_pc=0, out_instr=0x100.
REQ-038 With queue full, in_valid=1, pc=4, out_ready=1 for one cycle -> pc=0 popped, pc=4 not accepted, count=3, out_pc=1.
REQ-039 Continuous push and pop for 10 cycles at count=2 -> count stays 2, out_pc sequence increments by 1, pointers wrap with no loss.
REQ-040 count=3, assert flush with in_valid=1, pc=0x40 -> next cycle count=0, out_valid=0, out_instr=0; pc=0x40 discarded.
REQ-041 Empty queue, out_ready=1 and in_valid=0 for 3 cycles -> count stays 0, out_pc=0, no underflow.
REQ-042 count=2, rst=1 together with flush, push and pop -> next cycle count=0, in_ready=1, out_valid=0.
